sliding_window_max: RTL
=======================

# sliding_window_max

Streaming sliding-window maximum over the most recent LENGTH accepted samples. For every accepted sample it reports the window maximum and that maximum's age. It sits directly downstream of the sample delay line in the max16 datapath and consumes the same sample stream. The window store is built from its own shift stage, followed by a pipelined comparator tree.

## Interface
Parameters:
- DATA_WIDTH, 8, sample width; unsigned.
- LENGTH, 16, window depth; power of two, 2 to 64.
- IDX_W, $clog2(LENGTH), width of the age output.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- clr, input, 1, synchronous flush; empties the window.
- in_valid, input, 1, din is accepted on this edge; no backpressure.
- din, input, DATA_WIDTH, sample.
- dout_valid, output, 1, one-cycle pulse; dout and dout_idx are valid.
- dout, output, DATA_WIDTH, maximum of the window.
- dout_idx, output, IDX_W, age of the maximum; 0 = newest sample.
- full, output, 1, window holds LENGTH samples since the last reset or clr.

## Operation
- Window store: LENGTH registers, w[0] newest.
  - On an edge with in_valid=1: w[0]<=din and w[i]<=w[i-1].
  - Otherwise w holds.
- Fill counter cnt, 0..LENGTH:
  - Increments per accepted sample and saturates at LENGTH.
  - full = (cnt==LENGTH).
- Comparator tree: L2=log2(LENGTH) registered stages.
  - Stage s holds LENGTH>>s {value, idx} pairs.
  - Each pair is the max of two stage s-1 pairs.
  - Tie-break: the smaller idx (newer sample) wins.
  - Stage 0 is w with idx=i.
  - Tree data registers update every cycle.
- Valid pipe: L2+1 bit shift register.
  - Entry bit = in_valid AND (cnt==LENGTH-1 OR cnt==LENGTH), i.e. the window is full including the sample being accepted.
  - dout_valid is the last bit.
- The sample window is max-reduced only once full; partial windows never produce dout_valid.
- clr:
  - Zeroes w and cnt, and clears all valid-pipe bits.
  - Tree data may hold stale values; dout_valid stays low so they are never reported.
  - clr with in_valid on the same edge: clr wins and the sample is dropped.
- Arithmetic: unsigned compare only; no width growth. dout equals one stored sample exactly.

## Timing
- Reset (rst=1, asynchronous):
  - w, cnt, tree and valid pipe all go to 0.
  - dout=0, dout_idx=0, dout_valid=0, full=0.
  - Takes effect immediately, without waiting for a clock.
- Release: the first edge after rst falls may accept a sample.
- Latency: sample accepted on edge k → dout_valid high in the cycle after edge k+L2+1.
  - That is L2+1 cycles: 5 for LENGTH=16.
- Throughput: one result per cycle with in_valid held high. Gaps in in_valid produce gaps in dout_valid.
- Between pulses dout and dout_idx hold the last tree result and carry no meaning.
- full rises on the edge that accepts the LENGTH-th sample.
- Reset or clr mid-pipeline: in-flight results are discarded and no dout_valid follows. Refill needs LENGTH new samples.
- Window wrap-around: the oldest sample leaves on the same edge a new one enters. A maximum of age LENGTH-1 is replaced on the next accepted sample.

## Test plan
- Ramp: reset, then din=1..16 on consecutive cycles.
  - No dout_valid for samples 1-15.
  - Five cycles after sample 16 is accepted: one pulse with dout=16, dout_idx=0; full=1.
- Age tracking: after the ramp, feed 16 zeros.
  - Outputs are dout=16 with dout_idx=1,2,…,15.
  - Then dout=0, dout_idx=0 on the 16th zero.
- Ties and order:
  - Window of sixteen 5s: dout=5, dout_idx=0.
  - Then din=200, then 5s: dout=200 with idx incrementing until it ages out after 16 samples.
- Gaps: ramp 1..20 with in_valid toggling 1-0.
  - dout_valid pulses only for accepted samples 16..20, each 5 cycles after acceptance.
  - Values are 16..20; dout holds between pulses.
- clr mid-stream: full window of 9s, then assert clr together with in_valid din=50.
  - 50 is dropped; in-flight pulses are suppressed; full=0.
  - The next valid output appears only after 16 new samples.
- Async reset: assert rst mid-cycle while 3 results are in flight.
  - All outputs go to 0 immediately, and no pulse follows after release.
  - Max value 255 and min value 0 are handled correctly.

Source files
------------

// File: rtl/sliding_window_max.sv
// Streaming sliding-window maximum: a LENGTH-deep shift window feeding a registered
// binary comparator tree that reports the window maximum and its age.
module sliding_window_max #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LENGTH     = 16,
    parameter int unsigned IDX_W      = $clog2(LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [IDX_W-1:0]      dout_idx,
    output logic                  full
);

    localparam int unsigned L2    = $clog2(LENGTH);
    localparam int unsigned CNT_W = $clog2(LENGTH + 1);

    logic [DATA_WIDTH-1:0] r_win [LENGTH];
    logic [CNT_W-1:0]      r_cnt;
    logic [L2:0]           r_vpipe;
    logic                  w_win_full;

    // Heap-ordered tree: node n has children 2n and 2n+1; node 1 is the root.
    logic [DATA_WIDTH-1:0] r_node_val [1:LENGTH-1];
    logic [IDX_W-1:0]      r_node_idx [1:LENGTH-1];

    // The window is complete once the sample being accepted brings it to LENGTH.
    assign w_win_full = in_valid && (r_cnt >= CNT_W'(LENGTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(LENGTH); i++) r_win[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < int'(LENGTH); i++) r_win[i] <= '0;
        end else if (in_valid) begin
            r_win[0] <= din;
            for (int i = 1; i < int'(LENGTH); i++) r_win[i] <= r_win[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            full       <= 1'b0;
            r_vpipe    <= '0;
            dout_valid <= 1'b0;
        end else if (clr) begin
            r_cnt      <= '0;
            full       <= 1'b0;
            r_vpipe    <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (in_valid && (r_cnt != CNT_W'(LENGTH))) r_cnt <= r_cnt + CNT_W'(1);
            if (w_win_full) full <= 1'b1;
            r_vpipe    <= {r_vpipe[L2-1:0], w_win_full};
            dout_valid <= r_vpipe[L2];
        end
    end

    for (genvar n = 1; n < int'(LENGTH); n++) begin : g_node
        logic [DATA_WIDTH-1:0] w_a_val;
        logic [DATA_WIDTH-1:0] w_b_val;
        logic [IDX_W-1:0]      w_a_idx;
        logic [IDX_W-1:0]      w_b_idx;

        if (2 * n >= int'(LENGTH)) begin : g_leaf
            assign w_a_val = r_win[2*n - int'(LENGTH)];
            assign w_b_val = r_win[2*n + 1 - int'(LENGTH)];
            assign w_a_idx = IDX_W'(2*n - int'(LENGTH));
            assign w_b_idx = IDX_W'(2*n + 1 - int'(LENGTH));
        end else begin : g_inner
            assign w_a_val = r_node_val[2*n];
            assign w_b_val = r_node_val[2*n + 1];
            assign w_a_idx = r_node_idx[2*n];
            assign w_b_idx = r_node_idx[2*n + 1];
        end

        // Left child always covers newer samples, so it wins ties.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_node_val[n] <= '0;
                r_node_idx[n] <= '0;
            end else if (w_b_val > w_a_val) begin
                r_node_val[n] <= w_b_val;
                r_node_idx[n] <= w_b_idx;
            end else begin
                r_node_val[n] <= w_a_val;
                r_node_idx[n] <= w_a_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout     <= '0;
            dout_idx <= '0;
        end else begin
            dout     <= r_node_val[1];
            dout_idx <= r_node_idx[1];
        end
    end

endmodule
